smbs_tx: RTL and testbench
==========================

Name: smbs_tx

Overview:
- Transmitting end of the serial multi-bus switch: accepts a parallel word plus a destination (one-hot port, 2-bit line) over a valid/ready handshake.
- Drives serOut, P_select and L_select, which connect directly to serIn/P_select/L_select of the switch demux.
- Holds selects stable for a programmable settle time, then shifts the word out LSB-first, one bit per clock.
- Sits between the packet source and the switch.

Parameters:
- DATA_W, 8, payload width in bits (1..32).
- SETUP_CYCLES, 2, cycles selects are held with serOut=0 before the first bit (>=1); covers switch propagation delay.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  source offers a frame
- in_ready  output  1  block can accept a frame
- in_data  input  DATA_W  payload
- in_port  input  4  one-hot destination port
- in_line  input  2  destination line within port
- serOut  output  1  serial data to switch
- P_select  output  4  port select to switch
- L_select  output  2  line select to switch
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse, frame completed
- err  output  1  one-cycle pulse, frame rejected

Behaviour:
- Reset: the single clock is clk; reset rst is synchronous and active-high. On rst=1 at a clk edge:
  - State=IDLE, all registers cleared.
  - serOut=0, P_select=0, L_select=0, busy=0, done=0, err=0.
  - in_ready=1 from the first cycle after rst deasserts.
  - Reset mid-frame aborts the frame immediately; no done pulse.
- All outputs are registered except in_ready, which is 1 iff state==IDLE and rst==0.
- Accept: in_valid && in_ready at an edge latches in_data, in_port and in_line. in_valid while not ready is ignored; the source must hold it.
- Validation at accept: in_port must have exactly one bit set (popcount==1).
  - Otherwise: err=1 for one cycle, state stays IDLE, no selects driven.
  - in_ready stays 1, so back-to-back submission is allowed.
- States:
  - IDLE: outputs zero.
  - SETUP:
    - P_select=latched port, L_select=latched line, serOut=0, busy=1.
    - Lasts SETUP_CYCLES cycles, then SHIFT.
  - SHIFT:
    - Selects held, busy=1.
    - serOut=data[i] for i=0..DATA_W-1, one per cycle, LSB first.
    - Bit counter width $clog2(DATA_W+1). After the last bit, go to DONE.
  - DONE:
    - One cycle: done=1, busy=0, P_select=0, L_select=0, serOut=0.
    - Next state IDLE.
- Timing: accept at edge k gives SETUP at k+1, first data bit at k+1+SETUP_CYCLES, DONE at k+1+SETUP_CYCLES+DATA_W.
  - Minimum frame-to-frame spacing is SETUP_CYCLES+DATA_W+2 cycles.
- Selects never change while busy=1. P_select is all-zero whenever busy=0, so switch outputs fall to 0 between frames.
- Input changes after accept have no effect on the frame in flight.

Optional Feature:
- Macro: SMBS_TX_PARITY_EN.
- Defined:
  - SHIFT runs DATA_W+1 cycles; the final bit is even parity (XOR of all payload bits).
  - The DONE timing shifts by +1.
- Undefined: no parity bit; timing exactly as above.

Decomposition:
- Package smbs_pkg holds:
  - typedef enum logic [1:0] tx_state_t {IDLE, SETUP, SHIFT, DONE}
  - localparam NUM_PORTS=4, LINES_PER_PORT=4, LINE_W=2
  - function onehot_ok(logic [3:0])
- The switch demux imports the same constants.
- One natural sub-module: smbs_tx_shreg, a loadable right-shift register with bit counter and last-bit flag. The FSM lives in smbs_tx.

Test Plan:
- Reset mid-SHIFT: assert rst during bit 3 of frame 0xA5 -> next edge all outputs 0, in_ready=1, no done.
- Basic frame: DATA_W=8, SETUP_CYCLES=2, in_data=0xA5, in_port=4'b0100, in_line=2'b11, accept at edge 0.
  - Required: P_select=0100 and L_select=11 from cycle 1.
  - serOut=1,0,1,0,0,1,0,1 on cycles 3..10.
  - done=1 at cycle 11, P_select=0 at cycle 11.
- Invalid port: in_port=4'b0110 (also 4'b0000) -> err pulse next cycle, busy stays 0, selects 0, in_ready=1.
- Back-to-back: in_valid held high with 0x01 then 0xFF -> second accept in the cycle after DONE. No select change during either frame; spacing 12 cycles.
- Input change after accept: change in_data/in_port while busy -> serial stream and selects unchanged.
- With SMBS_TX_PARITY_EN, in_data=0x07: parity bit=1 on cycle 11, done at cycle 12. With 0x03: parity bit=0.

Source files
------------

// File: rtl/smbs_pkg.sv
// Shared constants and types for the serial multi-bus switch (tx side and demux).
package smbs_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } tx_state_t;

   localparam int unsigned NUM_PORTS      = 4;
   localparam int unsigned LINES_PER_PORT = 4;
   localparam int unsigned LINE_W         = 2;

   // True when exactly one port bit is set.
   function automatic logic onehot_ok(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

endpackage

// File: rtl/smbs_tx_shreg.sv
// Loadable right-shift register with a remaining-bit counter.
// 'last' is high once every loaded bit has been shifted out.
module smbs_tx_shreg #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] load_data,
   output logic         bit_out,
   output logic         last
);

   localparam int unsigned CNT_W = $clog2(W + 1);

   logic [W-1:0]     sr;
   logic [CNT_W-1:0] cnt;

   // Load a new word or shift one bit toward the LSB.
   always_ff @(posedge clk) begin
      if (rst) begin
         sr  <= '0;
         cnt <= '0;
      end else if (load) begin
         sr  <= load_data;
         cnt <= CNT_W'(W);
      end else if (shift) begin
         sr  <= sr >> 1;
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign bit_out = sr[0];
   assign last    = (cnt == '0);

endmodule

// File: rtl/smbs_tx.sv
// Serial multi-bus switch transmitter: accepts word+destination, holds the
// selects for a settle time, then shifts the word out LSB-first.
// Optional build macro SMBS_TX_PARITY_EN appends an even-parity bit.
module smbs_tx
   import smbs_pkg::*;
#(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned SETUP_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_W-1:0]    in_data,
   input  logic [NUM_PORTS-1:0] in_port,
   input  logic [LINE_W-1:0]    in_line,
   output logic                 serOut,
   output logic [NUM_PORTS-1:0] P_select,
   output logic [LINE_W-1:0]    L_select,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

`ifdef SMBS_TX_PARITY_EN
   localparam int unsigned FRAME_W = DATA_W + 1;
`else
   localparam int unsigned FRAME_W = DATA_W;
`endif

   localparam int unsigned SET_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;

   tx_state_t              state_q, state_d;
   logic [SET_W-1:0]       setup_q, setup_d;
   logic [NUM_PORTS-1:0]   p_q, p_d;
   logic [LINE_W-1:0]      l_q, l_d;
   logic                   ser_q, ser_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;
   logic                   load, shift;
   logic                   bit_out, last;
   logic [FRAME_W-1:0]     frame;

`ifdef SMBS_TX_PARITY_EN
   assign frame = {^in_data, in_data};
`else
   assign frame = in_data;
`endif

   assign in_ready = (state_q == IDLE) && !rst;

   smbs_tx_shreg #(
      .W (FRAME_W)
   ) u_shreg (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .shift     (shift),
      .load_data (frame),
      .bit_out   (bit_out),
      .last      (last)
   );

   // Next-state and next-output logic; all outputs are registered alongside the state.
   always_comb begin
      state_d = state_q;
      setup_d = setup_q;
      p_d     = p_q;
      l_d     = l_q;
      ser_d   = 1'b0;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      load    = 1'b0;
      shift   = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               if (onehot_ok(in_port)) begin
                  state_d = SETUP;
                  setup_d = SET_W'(SETUP_CYCLES - 1);
                  p_d     = in_port;
                  l_d     = in_line;
                  busy_d  = 1'b1;
                  load    = 1'b1;
               end else begin
                  // Rejected frame: stay idle and ready for the next offer.
                  err_d = 1'b1;
               end
            end
         end
         SETUP: begin
            if (setup_q == '0) begin
               state_d = SHIFT;
               ser_d   = bit_out;
               shift   = 1'b1;
            end else begin
               setup_d = setup_q - SET_W'(1);
            end
         end
         SHIFT: begin
            if (last) begin
               state_d = DONE;
               p_d     = '0;
               l_d     = '0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               ser_d = bit_out;
               shift = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         setup_q <= '0;
         p_q     <= '0;
         l_q     <= '0;
         ser_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         setup_q <= setup_d;
         p_q     <= p_d;
         l_q     <= l_d;
         ser_q   <= ser_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign serOut   = ser_q;
   assign P_select = p_q;
   assign L_select = l_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_smbs_tx.sv
// Directed self-checking bench for smbs_tx (DATA_W=8, SETUP_CYCLES=2).
module tb_smbs_tx;

   localparam int unsigned DATA_W       = 8;
   localparam int unsigned SETUP_CYCLES = 2;
`ifdef SMBS_TX_PARITY_EN
   localparam int unsigned NBITS = DATA_W + 1;
`else
   localparam int unsigned NBITS = DATA_W;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [3:0]        in_port;
   logic [1:0]        in_line;
   logic              serOut;
   logic [3:0]        P_select;
   logic [1:0]        L_select;
   logic              busy;
   logic              done;
   logic              err;

   int total = 0;
   int bad   = 0;

   smbs_tx #(
      .DATA_W       (DATA_W),
      .SETUP_CYCLES (SETUP_CYCLES)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_port  (in_port),
      .in_line  (in_line),
      .serOut   (serOut),
      .P_select (P_select),
      .L_select (L_select),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   // Advance one clock edge; sample/drive 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called in cycle 1 after an accept edge; checks through the DONE cycle.
   task automatic frame_check(input logic [7:0] data, input logic [3:0] port,
                              input logic [1:0] line);
      logic [8:0] fr;
      fr = {^data, data};
      for (int c = 0; c < SETUP_CYCLES; c++) begin
         chk("setup_psel", 32'(P_select), 32'(port));
         chk("setup_lsel", 32'(L_select), 32'(line));
         chk("setup_ser", 32'(serOut), 32'd0);
         chk("setup_busy", 32'(busy), 32'd1);
         tick();
      end
      for (int i = 0; i < NBITS; i++) begin
         chk("shift_ser", 32'(serOut), 32'(fr[i]));
         chk("shift_psel", 32'(P_select), 32'(port));
         chk("shift_lsel", 32'(L_select), 32'(line));
         chk("shift_busy", 32'(busy), 32'd1);
         tick();
      end
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_busy", 32'(busy), 32'd0);
      chk("done_psel", 32'(P_select), 32'd0);
      chk("done_lsel", 32'(L_select), 32'd0);
      chk("done_ser", 32'(serOut), 32'd0);
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      in_port  = '0;
      in_line  = '0;
      tick();
      tick();
      chk("rst_ready_low", 32'(in_ready), 32'd0);
      rst = 1'b0;
      #1;
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_psel", 32'(P_select), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_ser", 32'(serOut), 32'd0);

      // Basic frame 0xA5 to port 0100 line 11.
      in_valid = 1'b1;
      in_data  = 8'hA5;
      in_port  = 4'b0100;
      in_line  = 2'b11;
      tick();
      in_valid = 1'b0;
      chk("busy_ready", 32'(in_ready), 32'd0);
      frame_check(8'hA5, 4'b0100, 2'b11);
      tick();
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_ready", 32'(in_ready), 32'd1);

      // Invalid ports: two bits set, then none.
      in_valid = 1'b1;
      in_port  = 4'b0110;
      tick();
      chk("inv2_err", 32'(err), 32'd1);
      chk("inv2_busy", 32'(busy), 32'd0);
      chk("inv2_psel", 32'(P_select), 32'd0);
      chk("inv2_ready", 32'(in_ready), 32'd1);
      in_port = 4'b0000;
      tick();
      chk("inv0_err", 32'(err), 32'd1);
      chk("inv0_busy", 32'(busy), 32'd0);
      chk("inv0_lsel", 32'(L_select), 32'd0);
      in_valid = 1'b0;
      tick();
      chk("inv_err_clear", 32'(err), 32'd0);

      // Back-to-back with valid held; inputs change right after the first accept.
      in_valid = 1'b1;
      in_data  = 8'h01;
      in_port  = 4'b0001;
      in_line  = 2'b00;
      tick();
      in_data = 8'hFF;
      in_port = 4'b1000;
      in_line = 2'b01;
      frame_check(8'h01, 4'b0001, 2'b00);
      tick();
      chk("b2b_idle_ready", 32'(in_ready), 32'd1);
      chk("b2b_idle_busy", 32'(busy), 32'd0);
      tick();
      in_valid = 1'b0;
      frame_check(8'hFF, 4'b1000, 2'b01);
      tick();
      chk("b2b_end_ready", 32'(in_ready), 32'd1);

      // Reset during bit 3 of 0xA5.
      in_valid = 1'b1;
      in_data  = 8'hA5;
      in_port  = 4'b0010;
      in_line  = 2'b10;
      tick();
      in_valid = 1'b0;
      for (int c = 1; c < 1 + SETUP_CYCLES + 3; c++) tick();
      chk("pre_rst_bit3", 32'(serOut), 32'd0);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      chk("midrst_psel", 32'(P_select), 32'd0);
      chk("midrst_lsel", 32'(L_select), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_ser", 32'(serOut), 32'd0);
      rst = 1'b0;
      #1;
      chk("midrst_ready", 32'(in_ready), 32'd1);
      for (int c = 0; c < 12; c++) begin
         tick();
         chk("post_rst_nodone", 32'({done, busy}), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
